// File: rtl/seg_display_scan.sv
// Time-multiplexed seven-segment scanner for the debug display. Values are
// staged on load and copied to the displayed shadow only at frame wrap.
module seg_display_scan #(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  load,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int   CW  = $clog2(REFRESH_DIV);
    localparam int   IW  = $clog2(DIGITS);
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   stg_data, shd_data;
    logic [DIGITS-1:0]     stg_dp, shd_dp;
    logic [DIGITS-1:0]     stg_blank, shd_blank;

    logic                  tick, wrap;
    logic [3:0]            cur_nib;
    logic [6:0]            cur_seg;
    logic                  cur_dp;
    logic [DIGITS-1:0]     cur_an;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h77;
            4'hB:    return 7'h7C;
            4'hC:    return 7'h39;
            4'hD:    return 7'h5E;
            4'hE:    return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign tick = (cnt == CW'(REFRESH_DIV - 1));
    assign wrap = tick && (idx == IW'(DIGITS - 1));

    // Active-high view of the digit currently selected by idx; blanking darkens segments and dp only.
    always_comb begin
        cur_nib = shd_data[{idx, 2'b00} +: 4];
        cur_an  = DIGITS'(1) << idx;
        cur_seg = hex_to_seg(cur_nib);
        cur_dp  = shd_dp[idx];
        if (shd_blank[idx]) begin
            cur_seg = 7'h00;
            cur_dp  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            stg_data   <= '0;
            stg_dp     <= '0;
            stg_blank  <= '0;
            shd_data   <= '0;
            shd_dp     <= '0;
            shd_blank  <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            an         <= {DIGITS{INV}};
            seg        <= {7{INV}};
            dp         <= INV;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end

            // Shadow copies the pre-load staging; a coincident load re-arms pending below.
            if (wrap && pending) begin
                shd_data  <= stg_data;
                shd_dp    <= stg_dp;
                shd_blank <= stg_blank;
                pending   <= 1'b0;
            end
            if (load) begin
                stg_data  <= data;
                stg_dp    <= dp_in;
                stg_blank <= blank_mask;
                pending   <= 1'b1;
            end

            frame_done <= wrap;
            an         <= cur_an ^ {DIGITS{INV}};
            seg        <= cur_seg ^ {7{INV}};
            dp         <= cur_dp ^ INV;
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with 4 digits, 4-cycle slots, active-low outputs.
module tb_seg_display_scan;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;
    localparam int ACTIVE_LOW  = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  blank_mask;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        pending;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    int k = 0;

    typedef struct {
        string       name;
        logic [15:0] data;
        logic [3:0]  dp_in;
        logic [3:0]  blank;
        logic [27:0] seg_exp;
        logic [3:0]  dp_exp;
    } vec_t;

    vec_t vecs[4];

    seg_display_scan #(
        .DIGITS(DIGITS),
        .REFRESH_DIV(REFRESH_DIV),
        .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data(data),
        .dp_in(dp_in),
        .blank_mask(blank_mask),
        .load(load),
        .an(an),
        .seg(seg),
        .dp(dp),
        .pending(pending),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at k=%0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    // k counts edges since the last reset edge; frame_done and one-hot an are checked every cycle.
    task automatic step();
        logic [31:0] fd_exp;
        @(posedge clk);
        #1;
        if (rst) k = 0;
        else k++;
        fd_exp = (k > 0 && (k % 16) == 0) ? 32'd1 : 32'd0;
        check_output("frame_done", {31'd0, frame_done}, fd_exp);
        check_output("an_onehot", ($countones(~an) <= 1) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_phase(input int p);
        do step(); while ((k % 16) != p);
    endtask

    task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] dpi, input logic [3:0] bl);
        data       = d;
        dp_in      = dpi;
        blank_mask = bl;
        load       = 1'b1;
        step();
        load       = 1'b0;
        data       = 16'hDEAD;
    endtask

    task automatic check_inactive(input string nm);
        check_output({nm, "_an"}, {28'd0, an}, 32'hF);
        check_output({nm, "_seg"}, {25'd0, seg}, 32'h7F);
        check_output({nm, "_dp"}, {31'd0, dp}, 32'd1);
    endtask

    // Called right after a wrap edge; checks every cycle of the following frame.
    task automatic check_frame(input string nm, input logic [27:0] seg_exp, input logic [3:0] dp_exp);
        logic [3:0] one;
        logic [3:0] an_exp;
        int d;
        one = 4'b0001;
        for (int c = 0; c < 16; c++) begin
            step();
            d = c / 4;
            an_exp = ~(one << d);
            check_output({nm, "_an"}, {28'd0, an}, {28'd0, an_exp});
            check_output({nm, "_seg"}, {25'd0, seg}, {25'd0, seg_exp[d*7 +: 7]});
            check_output({nm, "_dp"}, {31'd0, dp}, {31'd0, dp_exp[d]});
        end
    endtask

    initial begin
        vecs[0] = '{"load_apply", 16'hA5C3, 4'b0010, 4'b0000, {7'h08, 7'h12, 7'h46, 7'h30}, 4'b1101};
        vecs[1] = '{"blank_d2",   16'h8421, 4'b0100, 4'b0100, {7'h00, 7'h7F, 7'h24, 7'h79}, 4'b1111};
        vecs[2] = '{"hex_dp",     16'h9E6B, 4'b1001, 4'b0000, {7'h10, 7'h06, 7'h02, 7'h03}, 4'b0110};
        vecs[3] = '{"blank_d3",   16'h7D04, 4'b0000, 4'b1000, {7'h7F, 7'h21, 7'h40, 7'h19}, 4'b1111};

        rst        = 1'b1;
        load       = 1'b0;
        data       = 16'h0;
        dp_in      = 4'h0;
        blank_mask = 4'h0;

        for (int i = 0; i < 3; i++) begin
            step();
            check_inactive("reset");
            check_output("reset_pending", {31'd0, pending}, 32'd0);
        end
        rst = 1'b0;
        step();
        check_output("first_an", {28'd0, an}, 32'hE);
        check_output("first_seg", {25'd0, seg}, 32'h40);
        check_output("first_dp", {31'd0, dp}, 32'd1);

        for (int v = 0; v < 4; v++) begin
            wait_phase(5);
            apply_stimulus(vecs[v].data, vecs[v].dp_in, vecs[v].blank);
            check_output({vecs[v].name, "_pend_set"}, {31'd0, pending}, 32'd1);
            wait_phase(15);
            check_output({vecs[v].name, "_pend_hold"}, {31'd0, pending}, 32'd1);
            step();
            check_output({vecs[v].name, "_pend_clr"}, {31'd0, pending}, 32'd0);
            check_frame(vecs[v].name, vecs[v].seg_exp, vecs[v].dp_exp);
        end

        // No tearing: two loads in one frame, the current frame keeps the old shadow.
        wait_phase(2);
        apply_stimulus(16'h1111, 4'b0000, 4'b0000);
        wait_phase(9);
        apply_stimulus(16'h2222, 4'b0000, 4'b0000);
        wait_phase(12);
        check_output("tear_old_an2", {28'd0, an}, 32'hB);
        check_output("tear_old_seg2", {25'd0, seg}, 32'h21);
        wait_phase(15);
        check_output("tear_old_seg3", {25'd0, seg}, 32'h7F);
        step();
        check_output("tear_pend_clr", {31'd0, pending}, 32'd0);
        check_frame("tear_new", {4{7'h24}}, 4'b1111);

        // Load exactly on the wrap edge while 0000 is pending.
        wait_phase(5);
        apply_stimulus(16'h0000, 4'b0000, 4'b0000);
        wait_phase(15);
        apply_stimulus(16'hFFFF, 4'b0000, 4'b0000);
        check_output("wrapload_pend", {31'd0, pending}, 32'd1);
        check_frame("wrapload_zero", {4{7'h40}}, 4'b1111);
        check_output("wrapload_pend_clr", {31'd0, pending}, 32'd0);
        check_frame("wrapload_f", {4{7'h0E}}, 4'b1111);

        // Reset while digit 2 is active and a value is pending.
        wait_phase(5);
        apply_stimulus(16'h3333, 4'b1111, 4'b0000);
        wait_phase(9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_inactive("midrst");
        check_output("midrst_pending", {31'd0, pending}, 32'd0);
        step();
        check_output("midrst_an", {28'd0, an}, 32'hE);
        check_output("midrst_seg", {25'd0, seg}, 32'h40);
        check_output("midrst_pend1", {31'd0, pending}, 32'd0);
        wait_phase(0);
        check_frame("midrst_frame", {4{7'h40}}, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
